clock_modulo_counter: RTL and testbench

CLOCK_MODULO_COUNTER -- requirements
Module: clock_modulo_counter

---
 rtl/clock_pkg.sv | 44 ++++
 rtl/mod_add.sv | 36 +++
 rtl/clock_modulo_counter.sv | 115 +++++++++++
 tb/tb_clock_modulo_counter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the clock counter stages: the default moduli of the
// hour (24) and minute/second (60) stages, the default reset value, and the
// per-cycle command decode used by every counter stage.
// ----------------------------------------------------------------------------
package clock_pkg;

    localparam int MOD_HOURS           = 24;
    localparam int MOD_MINUTES         = 60;
    localparam int RESET_VALUE_DEFAULT = 0;

    // Effective command for one cycle, after priority resolution.
    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_UP,
        CMD_DOWN,
        CMD_CLEAR,        // explicit clear, or up and down requested together
        CMD_LOAD,
        CMD_LOAD_REJECT   // load value outside 0..MODULUS-1
    } cmd_e;

    // Clear beats load, load beats the up/down pair.
    function automatic cmd_e decode_cmd(
        input logic clr,
        input logic load,
        input logic load_ok,
        input logic up,
        input logic down
    );
        if (clr)
            return CMD_CLEAR;
        if (load)
            return load_ok ? CMD_LOAD : CMD_LOAD_REJECT;
        if (up && down)
            return CMD_CLEAR;
        if (up)
            return CMD_UP;
        if (down)
            return CMD_DOWN;
        return CMD_HOLD;
    endfunction

endpackage

// File: rtl/mod_add.sv
// ----------------------------------------------------------------------------
// mod_add
// Combinational modular adder: sum = (a + b) mod MODULUS, for operands that
// are both already in 0..MODULUS-1. The addition is carried at WIDTH+1 bits
// so a carry out of the WIDTH-bit range is never lost before the wrap.
//
// Ports:
//   a    in  WIDTH  first operand  (0..MODULUS-1)
//   b    in  WIDTH  second operand (0..MODULUS-1)
//   sum  out WIDTH  (a + b) mod MODULUS
// ----------------------------------------------------------------------------
module mod_add
    import clock_pkg::*;
#(
    parameter int MODULUS = MOD_HOURS,
    parameter int WIDTH   = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH:0] raw_sum;
    logic [WIDTH:0] wrapped;

    // Both operands are below MODULUS, so one conditional subtraction is
    // enough to bring the sum back into range.
    always_comb begin
        raw_sum = {1'b0, a} + {1'b0, b};
        wrapped = (raw_sum >= MOD_EXT) ? (raw_sum - MOD_EXT) : raw_sum;
        sum     = wrapped[WIDTH-1:0];
    end

endmodule

// File: rtl/clock_modulo_counter.sv
// ----------------------------------------------------------------------------
// clock_modulo_counter
// One cascadable stage of a clock: an up/down counter over 0..MODULUS-1 with
// clear, range-checked load, wrap indications for the neighbouring stage, and
// a display output that can be shifted by an offset (summer-time style)
// without touching the stored count.
//
// Ports:
//   i_clk          in   1      clock, all state changes on the rising edge
//   i_rstn         in   1      asynchronous active-low reset
//   i_up           in   1      step up by one
//   i_down         in   1      step down by one (with i_up: clear)
//   i_clr          in   1      synchronous clear to RESET_VALUE
//   i_load         in   1      synchronous load of i_load_value
//   i_load_value   in   WIDTH  value to load, accepted only if < MODULUS
//   i_offset_en    in   1      apply i_offset to o_display
//   i_offset       in   WIDTH  display offset, valid 0..MODULUS-1
//   o_count        out  WIDTH  registered count
//   o_display      out  WIDTH  count shifted by the offset, mod MODULUS
//   o_carryup      out  1      this cycle's up step wraps MODULUS-1 -> 0
//   o_borrowdown   out  1      this cycle's down step wraps 0 -> MODULUS-1
//   o_load_err     out  1      one-cycle pulse after a rejected load
//   o_offset_err   out  1      offset enabled but out of range
// ----------------------------------------------------------------------------
module clock_modulo_counter
    import clock_pkg::*;
#(
    parameter int MODULUS     = MOD_HOURS,
    parameter int WIDTH       = 5,
    parameter int RESET_VALUE = RESET_VALUE_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_up,
    input  logic             i_down,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_offset_en,
    input  logic [WIDTH-1:0] i_offset,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_display,
    output logic             o_carryup,
    output logic             o_borrowdown,
    output logic             o_load_err,
    output logic             o_offset_err
);

    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] COUNT_RST = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             load_err_q;
    logic             load_ok;
    logic             offset_ok;
    logic [WIDTH-1:0] offset_eff;
    cmd_e             cmd;

    // Range checks are done one bit wider so MODULUS == 2**WIDTH still works.
    assign load_ok   = ({1'b0, i_load_value} < MOD_EXT);
    assign offset_ok = ({1'b0, i_offset} < MOD_EXT);

    assign cmd = decode_cmd(i_clr, i_load, load_ok, i_up, i_down);

    always_comb begin
        // NOTE: assigning a default before the case means every path drives
        // count_d, so no latch is inferred for the unlisted commands.
        count_d = count_q;
        case (cmd)
            CMD_UP:    count_d = (count_q == COUNT_MAX) ? '0 : count_q + 1'b1;
            CMD_DOWN:  count_d = (count_q == '0) ? COUNT_MAX : count_q - 1'b1;
            CMD_CLEAR: count_d = COUNT_RST;
            CMD_LOAD:  count_d = i_load_value;
            default:   count_d = count_q;   // hold, rejected load
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs from before the edge; both registers take the async
    // reset, so a load in flight when reset hits leaves no error pulse behind.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count_q    <= COUNT_RST;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= (cmd == CMD_LOAD_REJECT);
        end
    end

    assign o_count    = count_q;
    assign o_load_err = load_err_q;

    // Wrap flags follow the resolved command, so clear/load/up+down never
    // produce a spurious cascade step.
    assign o_carryup    = (cmd == CMD_UP)   && (count_q == COUNT_MAX);
    assign o_borrowdown = (cmd == CMD_DOWN) && (count_q == '0);

    // An out-of-range offset is flagged and ignored: adding zero shows the
    // plain count.
    assign o_offset_err = i_offset_en && !offset_ok;
    assign offset_eff   = (i_offset_en && offset_ok) ? i_offset : '0;

    mod_add #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_display_add (
        .a   (count_q),
        .b   (offset_eff),
        .sum (o_display)
    );

endmodule

// File: tb/tb_clock_modulo_counter.sv
// ----------------------------------------------------------------------------
// tb_clock_modulo_counter
// Drives two counter instances with shared stimulus: an hour stage
// (MODULUS 24, WIDTH 5, reset 0) and a minute stage (MODULUS 60, WIDTH 6,
// reset 7). A reference model written with plain modulo arithmetic predicts
// every output and is compared on each falling clock edge; directed literal
// checks pin the model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_clock_modulo_counter;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       up, down, clr, load, oen;
    logic [5:0] lv, off;

    logic [4:0] c0, d0;
    logic       cu0, bd0, le0, oe0;
    logic [5:0] c1, d1;
    logic       cu1, bd1, le1, oe1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model state: index 0 = hour stage, index 1 = minute stage.
    int m_count [2] = '{0, 7};
    int m_err   [2] = '{0, 0};

    typedef struct {
        bit up, down, clr, load;
        int lv;
        bit oen;
        int off;
    } vec_t;

    always #5 clk = ~clk;

    clock_modulo_counter dut24 (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_up         (up),
        .i_down       (down),
        .i_clr        (clr),
        .i_load       (load),
        .i_load_value (lv[4:0]),
        .i_offset_en  (oen),
        .i_offset     (off[4:0]),
        .o_count      (c0),
        .o_display    (d0),
        .o_carryup    (cu0),
        .o_borrowdown (bd0),
        .o_load_err   (le0),
        .o_offset_err (oe0)
    );

    clock_modulo_counter #(
        .MODULUS     (60),
        .WIDTH       (6),
        .RESET_VALUE (7)
    ) dut60 (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_up         (up),
        .i_down       (down),
        .i_clr        (clr),
        .i_load       (load),
        .i_load_value (lv),
        .i_offset_en  (oen),
        .i_offset     (off),
        .o_count      (c1),
        .o_display    (d1),
        .o_carryup    (cu1),
        .o_borrowdown (bd1),
        .o_load_err   (le1),
        .o_offset_err (oe1)
    );

    // ---------------- reference model ----------------
    function automatic int mod_of(input int k);
        return (k == 0) ? 24 : 60;
    endfunction

    function automatic int rv_of(input int k);
        return (k == 0) ? 0 : 7;
    endfunction

    // Bus value as seen by stage k (hour stage only sees the low 5 bits).
    function automatic int trunc(input int v, input int k);
        return (k == 0) ? (v % 32) : (v % 64);
    endfunction

    function automatic int next_count(input int k, input int c);
        int m, v;
        m = mod_of(k);
        v = trunc(int'(lv), k);
        if (clr)          return rv_of(k);
        if (load)         return (v < m) ? v : c;
        if (up && down)   return rv_of(k);
        if (up)           return (c + 1) % m;
        if (down)         return (c + m - 1) % m;
        return c;
    endfunction

    function automatic int exp_carry(input int k, input int c);
        return (!clr && !load && up && !down && (c + 1 == mod_of(k))) ? 1 : 0;
    endfunction

    function automatic int exp_borrow(input int k, input int c);
        return (!clr && !load && down && !up && (c == 0)) ? 1 : 0;
    endfunction

    function automatic int exp_display(input int k, input int c);
        int o;
        o = trunc(int'(off), k);
        return (oen && o < mod_of(k)) ? (c + o) % mod_of(k) : c;
    endfunction

    function automatic int exp_offerr(input int k);
        return (oen && trunc(int'(off), k) >= mod_of(k)) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rstn) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                m_count[k] <= rv_of(k);
                m_err[k]   <= 0;
            end else begin
                m_count[k] <= next_count(k, m_count[k]);
                m_err[k]   <= (!clr && load && trunc(int'(lv), k) >= mod_of(k)) ? 1 : 0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m24 count",   int'(c0),  m_count[0]);
            check("m24 display", int'(d0),  exp_display(0, m_count[0]));
            check("m24 carry",   int'(cu0), exp_carry(0, m_count[0]));
            check("m24 borrow",  int'(bd0), exp_borrow(0, m_count[0]));
            check("m24 load_err",int'(le0), m_err[0]);
            check("m24 off_err", int'(oe0), exp_offerr(0));
            check("m60 count",   int'(c1),  m_count[1]);
            check("m60 display", int'(d1),  exp_display(1, m_count[1]));
            check("m60 carry",   int'(cu1), exp_carry(1, m_count[1]));
            check("m60 borrow",  int'(bd1), exp_borrow(1, m_count[1]));
            check("m60 load_err",int'(le1), m_err[1]);
            check("m60 off_err", int'(oe1), exp_offerr(1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input bit u, input bit dn, input bit c, input bit l,
                          input int v, input bit e, input int o);
        up   = u;
        down = dn;
        clr  = c;
        load = l;
        lv   = 6'(v);
        oen  = e;
        off  = 6'(o);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    vec_t vt [10];

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0);

        // Reset held across the first rising edge.
        #7;
        check("reset m24 count",    int'(c0),  0);
        check("reset m24 load_err", int'(le0), 0);
        check("reset m60 count",    int'(c1),  7);
        chk_en = 1'b1;
        #5 rstn = 1'b1;
        tick();

        // Bring the minute stage to 0 as well.
        set_in(0, 0, 0, 1, 0, 0, 0);
        tick();
        check("load0 m60 count", int'(c1), 0);

        // 24 up pulses: 1..23 then wrap to 0, carry only while at 23.
        set_in(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 24; i++) begin
            #1;
            check("up m24 carry", int'(cu0), (i == 24) ? 1 : 0);
            tick();
            check("up m24 count", int'(c0), i % 24);
            check("up m60 count", int'(c1), i);
        end

        // Down from 0 wraps to 23 with borrow.
        set_in(0, 1, 0, 0, 0, 0, 0);
        #1;
        check("down m24 borrow", int'(bd0), 1);
        check("down m60 borrow", int'(bd1), 0);
        tick();
        check("down m24 count", int'(c0), 23);
        check("down m60 count", int'(c1), 23);

        // Minute stage: 0 then down wraps to 59.
        set_in(0, 0, 0, 1, 0, 0, 0);
        tick();
        set_in(0, 1, 0, 0, 0, 0, 0);
        #1;
        check("down m60 borrow at 0", int'(bd1), 1);
        tick();
        check("down m60 wrap count", int'(c1), 59);

        // Valid load, rejected load, clear beats load.
        set_in(0, 0, 0, 1, 17, 0, 0);
        tick();
        check("load17 m24 count",    int'(c0),  17);
        check("load17 m24 load_err", int'(le0), 0);
        set_in(0, 0, 0, 1, 25, 0, 0);
        tick();
        check("load25 m24 count held", int'(c0),  17);
        check("load25 m24 load_err",   int'(le0), 1);
        check("load25 m60 count",      int'(c1),  25);
        check("load25 m60 load_err",   int'(le1), 0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("load_err pulse ends", int'(le0), 0);
        set_in(0, 0, 1, 1, 10, 0, 0);
        tick();
        check("clr+load m24 count", int'(c0), 0);
        check("clr+load m60 count", int'(c1), 7);

        // Display offset.
        set_in(0, 0, 0, 1, 23, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 1, 1);
        #1;
        check("off1 m24 display", int'(d0),  0);
        check("off1 m24 carry",   int'(cu0), 0);
        check("off1 m24 off_err", int'(oe0), 0);
        check("off1 m60 display", int'(d1),  24);
        set_in(0, 0, 0, 0, 0, 1, 24);
        #1;
        check("off24 m24 display", int'(d0),  23);
        check("off24 m24 off_err", int'(oe0), 1);
        check("off24 m60 display", int'(d1),  47);
        check("off24 m60 off_err", int'(oe1), 0);
        set_in(1, 0, 0, 0, 0, 1, 1);
        #1;
        check("off+up m24 carry",   int'(cu0), 1);
        check("off+up m24 display", int'(d0),  0);
        tick();
        check("off+up m24 count",   int'(c0),  0);
        check("off+up m24 display after", int'(d0), 1);

        // Up and down together clear without carry or borrow.
        set_in(0, 0, 0, 1, 9, 0, 0);
        tick();
        set_in(1, 1, 0, 0, 0, 0, 0);
        #1;
        check("updown m24 carry",  int'(cu0), 0);
        check("updown m24 borrow", int'(bd0), 0);
        tick();
        check("updown m24 count", int'(c0), 0);
        check("updown m60 count", int'(c1), 7);

        // Asynchronous reset mid-cycle.
        set_in(0, 0, 0, 1, 5, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2 rstn = 1'b0;
        #1;
        check("async rst m24 count", int'(c0), 0);
        check("async rst m60 count", int'(c1), 7);
        tick();
        #3 rstn = 1'b1;
        tick();

        // Reset during a rejected load leaves no error pulse.
        set_in(0, 0, 0, 1, 25, 0, 0);
        #2 rstn = 1'b0;
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        #3 rstn = 1'b1;
        tick();
        check("rst mid-load m24 load_err", int'(le0), 0);
        check("rst mid-load m24 count",    int'(c0),  0);

        // Directed vector table, checked by the model on every cycle.
        vt = '{
            '{up:1, down:0, clr:0, load:1, lv:24, oen:0, off:0},
            '{up:0, down:0, clr:0, load:1, lv:23, oen:1, off:23},
            '{up:1, down:0, clr:0, load:0, lv:0,  oen:1, off:23},
            '{up:0, down:1, clr:0, load:0, lv:0,  oen:1, off:31},
            '{up:0, down:1, clr:0, load:0, lv:0,  oen:1, off:60},
            '{up:0, down:0, clr:0, load:1, lv:31, oen:0, off:0},
            '{up:0, down:0, clr:0, load:1, lv:59, oen:1, off:59},
            '{up:1, down:0, clr:0, load:0, lv:0,  oen:1, off:1},
            '{up:1, down:1, clr:1, load:0, lv:0,  oen:0, off:0},
            '{up:0, down:0, clr:0, load:0, lv:0,  oen:0, off:0}
        };
        for (int i = 0; i < 10; i++) begin
            set_in(vt[i].up, vt[i].down, vt[i].clr, vt[i].load,
                   vt[i].lv, vt[i].oen, vt[i].off);
            tick();
        end
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
